// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock) with
// start/done handshake, overflow saturation and held result. BCD_LZB_EN enables leading-zero blanking.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 27,
  parameter int unsigned DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [BIN_W-1:0]   r_shift, w_shift_nxt;
  logic [BCD_W-1:0]   r_dig, w_dig_nxt;
  logic               r_sticky, w_sticky_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [BCD_W-1:0]   r_bcd, w_bcd_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic [BCD_W-1:0]   w_dig_adj;
  logic [BCD_W-1:0]   w_nines;

  // Shared add-3 stage: every working digit >= 5 is corrected before the shift.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign w_dig_adj[4*k +: 4] = (r_dig[4*k +: 4] >= 4'd5) ? (r_dig[4*k +: 4] + 4'd3)
                                                           : r_dig[4*k +: 4];
    assign w_nines[4*k +: 4]   = 4'd9;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_dig    <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_dig    <= w_dig_nxt;
      r_sticky <= w_sticky_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_bcd    <= w_bcd_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_dig_nxt    = r_dig;
    w_sticky_nxt = r_sticky;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_bcd_nxt    = r_bcd;
    w_ovf_nxt    = r_ovf;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          w_shift_nxt  = bin;
          w_dig_nxt    = '0;
          w_sticky_nxt = 1'b0;
          w_cnt_nxt    = CNT_W'(BIN_W);
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_dig_nxt    = {w_dig_adj[BCD_W-2:0], r_shift[BIN_W-1]};
        w_shift_nxt  = {r_shift[BIN_W-2:0], 1'b0};
        w_sticky_nxt = r_sticky | w_dig_adj[BCD_W-1];
        w_cnt_nxt    = r_cnt - CNT_W'(1);
        w_busy_nxt   = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_FINISH;
        end
      end

      S_FINISH: begin
        w_done_nxt  = 1'b1;
        w_bcd_nxt   = r_sticky ? w_nines : r_dig;
        w_ovf_nxt   = r_sticky;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
        // A start on the FINISH edge is taken directly so back-to-back requests cost BIN_W+1 cycles.
        if (start) begin
          w_shift_nxt  = bin;
          w_dig_nxt    = '0;
          w_sticky_nxt = 1'b0;
          w_cnt_nxt    = CNT_W'(BIN_W);
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_SHIFT;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

`ifdef BCD_LZB_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_fin;
  logic [DIGITS-1:0] w_nz;

  // Digit k (k >= 1) is blanked when it and every digit above it are zero.
  for (genvar k = 0; k < DIGITS; k++) begin : g_nz
    assign w_nz[k] = |r_dig[4*k +: 4];
  end
  assign w_blank_fin[0] = 1'b0;
  for (genvar k = 1; k < DIGITS; k++) begin : g_blank
    assign w_blank_fin[k] = ~r_sticky & ~(|w_nz[DIGITS-1:k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank <= '0;
    end else if (r_state == S_FINISH) begin
      r_blank <= w_blank_fin;
    end
  end

  assign blank = r_blank;
`else
  assign blank = '0;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: cycle-level arithmetic model plus directed literal checks,
// covering the default build (27b/8 digits) and a 4b/2 digit instance.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance
  logic        start = 1'b0;
  logic [26:0] bin = '0;
  logic        busy, done, ovf;
  logic [31:0] bcd;
  logic [7:0]  blank;

  bin_to_bcd_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .blank(blank)
  );

  // Small instance
  logic       start4 = 1'b0;
  logic [3:0] bin4 = '0;
  logic       busy4, done4, ovf4;
  logic [7:0] bcd4;
  logic [1:0] blank4;

  bin_to_bcd_seq #(.BIN_W(4), .DIGITS(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bin(bin4),
    .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4), .blank(blank4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic ref_ovf(input longint unsigned v, input int nd);
    longint unsigned lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    return (v >= lim);
  endfunction

  function automatic logic [39:0] ref_bcd(input longint unsigned v, input int nd);
    logic [39:0] r = '0;
    longint unsigned x = v;
    for (int i = 0; i < nd; i++) begin
      if (ref_ovf(v, nd)) r[4*i +: 4] = 4'd9;
      else begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic logic [9:0] ref_blank(input longint unsigned v, input int nd);
    logic [9:0] r = '0;
`ifdef BCD_LZB_EN
    longint unsigned p = 1;
    if (!ref_ovf(v, nd)) begin
      for (int k = 1; k < nd; k++) begin
        p = p * 10;
        r[k] = (v < p);
      end
    end
`else
    if (v != v) r = '1;
    if (nd < 0) r = '1;
`endif
    return r;
  endfunction

  // Model: a request takes BIN_W+1 edges; a new one may start on the edge its predecessor completes.
  int              m_cnt = 0;
  longint unsigned m_val = 0;
  logic            e_busy = 1'b0, e_done = 1'b0, e_ovf = 1'b0;
  logic [31:0]     e_bcd = '0;
  logic [7:0]      e_blank = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; e_busy <= 1'b0; e_done <= 1'b0; e_ovf <= 1'b0; e_bcd <= '0; e_blank <= '0;
    end else begin
      e_done <= (m_cnt == 1);
      if (m_cnt == 1) begin
        e_bcd   <= 32'(ref_bcd(m_val, 8));
        e_ovf   <= ref_ovf(m_val, 8);
        e_blank <= 8'(ref_blank(m_val, 8));
      end
      if (start && m_cnt <= 1) begin
        m_val <= longint'(bin); m_cnt <= 28; e_busy <= 1'b1;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1; e_busy <= (m_cnt > 1);
      end else e_busy <= 1'b0;
    end
  end

  int              m4_cnt = 0;
  longint unsigned m4_val = 0;
  logic            e4_busy = 1'b0, e4_done = 1'b0, e4_ovf = 1'b0;
  logic [7:0]      e4_bcd = '0;
  logic [1:0]      e4_blank = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_cnt <= 0; e4_busy <= 1'b0; e4_done <= 1'b0; e4_ovf <= 1'b0; e4_bcd <= '0; e4_blank <= '0;
    end else begin
      e4_done <= (m4_cnt == 1);
      if (m4_cnt == 1) begin
        e4_bcd   <= 8'(ref_bcd(m4_val, 2));
        e4_ovf   <= ref_ovf(m4_val, 2);
        e4_blank <= 2'(ref_blank(m4_val, 2));
      end
      if (start4 && m4_cnt <= 1) begin
        m4_val <= longint'(bin4); m4_cnt <= 5; e4_busy <= 1'b1;
      end else if (m4_cnt > 0) begin
        m4_cnt <= m4_cnt - 1; e4_busy <= (m4_cnt > 1);
      end else e4_busy <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  logic [7:0] q4_bcd[$];
  int         q4_cyc[$];

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("bcd", 64'(bcd), 64'(e_bcd));
    chk("ovf", 64'(ovf), 64'(e_ovf));
    chk("blank", 64'(blank), 64'(e_blank));
    chk("busy4", 64'(busy4), 64'(e4_busy));
    chk("done4", 64'(done4), 64'(e4_done));
    chk("bcd4", 64'(bcd4), 64'(e4_bcd));
    chk("ovf4", 64'(ovf4), 64'(e4_ovf));
    chk("blank4", 64'(blank4), 64'(e4_blank));
    if (done4) begin
      q4_bcd.push_back(bcd4);
      q4_cyc.push_back(cyc);
    end
  end

  // Waits (bounded) for done; returns number of busy cycles seen before it.
  task automatic wait_done(input string nm, output int nb, output logic got);
    nb = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) nb++;
        @(negedge clk);
      end
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic run(input string nm, input logic [26:0] v, input logic [31:0] x_bcd,
                     input logic x_ovf, input logic [7:0] x_blank_lzb);
    int nb;
    logic got;
    start = 1'b1; bin = v;
    @(negedge clk);
    start = 1'b0;
    wait_done(nm, nb, got);
    chk({nm, "_busy_cycles"}, 64'(nb), 64'd28);
    chk({nm, "_bcd"}, 64'(bcd), 64'(x_bcd));
    chk({nm, "_ovf"}, 64'(ovf), 64'(x_ovf));
`ifdef BCD_LZB_EN
    chk({nm, "_blank"}, 64'(blank), 64'(x_blank_lzb));
`else
    chk({nm, "_blank"}, 64'(blank), 64'(x_blank_lzb & 8'h00));
`endif
    @(negedge clk);
  endtask

  initial begin
    int nb, ndone;
    logic got;
    logic [7:0] exp4 [16];
    exp4 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
             8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_blank", 64'(blank), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run("zero", 27'd0, 32'h00000000, 1'b0, 8'hFE);
    run("mixed", 27'd12345678, 32'h12345678, 1'b0, 8'h00);
    run("max", 27'd99999999, 32'h99999999, 1'b0, 8'h00);
    run("over", 27'd100000000, 32'h99999999, 1'b1, 8'h00);

    // start re-asserted with new bin while busy: ignored
    start = 1'b1; bin = 27'd5;
    @(negedge clk);
    bin = 27'd777;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_done("busy_ign", nb, got);
    chk("busy_ign_bcd", 64'(bcd), 64'h5);
    chk("busy_ign_ovf", 64'(ovf), 64'd0);
    ndone = 0;
    repeat (35) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("busy_ign_extra_done", 64'(ndone), 64'd0);
    run("after_ign", 27'd777, 32'h00000777, 1'b0, 8'hF8);

    // Abort mid-conversion with reset
    start = 1'b1; bin = 27'd4242;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_bcd", 64'(bcd), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    chk("abort_blank", 64'(blank), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (35) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run("after_abort", 27'd4242, 32'h00004242, 1'b0, 8'hF0);

    // Small instance: sweep 0..15 with start held high
    start4 = 1'b1; bin4 = 4'd0;
    for (int v = 1; v < 16; v++) begin
      repeat (5) @(negedge clk);
      bin4 = 4'(v);
    end
    repeat (5) @(negedge clk);
    start4 = 1'b0;
    repeat (8) @(negedge clk);
    chk("sweep_count", 64'(q4_bcd.size()), 64'd16);
    for (int i = 0; i < 16 && i < q4_bcd.size(); i++) begin
      chk($sformatf("sweep_bcd%0d", i), 64'(q4_bcd[i]), 64'(exp4[i]));
      if (i > 0) chk($sformatf("sweep_period%0d", i), 64'(q4_cyc[i] - q4_cyc[i-1]), 64'd5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
